// File: rtl/phys_reg_wb_arbiter.sv
// phys_reg_wb_arbiter: round-robin writeback arbiter from per-requester holding entries onto register-file write ports.
// Optional stall statistic (Stall_Count_OUT) is built only when PRF_WB_STATS_EN is defined.
module phys_reg_wb_arbiter #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_REQ = 6,
  parameter int NUM_WPORTS = 4,
  localparam int REGLINES = $clog2(NUM_PHYS_REGS)
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [NUM_REQ-1:0]             Req_Valid_IN,
  input  logic [NUM_REQ*REGLINES-1:0]    Req_Tag_IN,
  input  logic [NUM_REQ*32-1:0]          Req_Data_IN,
  output logic [NUM_REQ-1:0]             Req_Ready_OUT,
  output logic [NUM_WPORTS-1:0]          WriteEnable_OUT,
  output logic [NUM_WPORTS*REGLINES-1:0] RegSelect_OUT,
  output logic [NUM_WPORTS*32-1:0]       WData_OUT
`ifdef PRF_WB_STATS_EN
  ,
  output logic [31:0]                    Stall_Count_OUT
`endif
);
  localparam int RW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int PW = NUM_WPORTS > 1 ? $clog2(NUM_WPORTS) : 1;
  logic [NUM_REQ-1:0][REGLINES-1:0] in_tag, tag_q;
  logic [NUM_REQ-1:0][31:0] in_data, data_q;
  logic [NUM_REQ-1:0] held, grant, xfer;
  logic [RW-1:0] rr_ptr, rr_nxt, idx, last;
  logic [RW:0] sum;
  logic [PW:0] cnt;
  logic clash;
  logic [NUM_WPORTS-1:0] port_v;
  logic [NUM_WPORTS-1:0][REGLINES-1:0] port_tag, sel_q;
  logic [NUM_WPORTS-1:0][31:0] port_data, wdat_q;
  assign in_tag = Req_Tag_IN;
  assign in_data = Req_Data_IN;
  assign Req_Ready_OUT = ~held | grant;
  assign xfer = Req_Valid_IN & Req_Ready_OUT;
  assign RegSelect_OUT = sel_q;
  assign WData_OUT = wdat_q;
  // Scan from rr_ptr; an entry whose tag matches one already granted this cycle waits.
  always_comb begin
    grant = '0;
    port_v = '0;
    port_tag = '0;
    port_data = '0;
    cnt = '0;
    last = rr_ptr;
    idx = rr_ptr;
    sum = '0;
    clash = 1'b0;
    for (int s = 0; s < NUM_REQ; s++) begin
      sum = {1'b0, rr_ptr} + (RW+1)'(s);
      idx = RW'(sum >= (RW+1)'(NUM_REQ) ? sum - (RW+1)'(NUM_REQ) : sum);
      clash = 1'b0;
      for (int j = 0; j < NUM_REQ; j++)
        clash = clash | (grant[j] && tag_q[j] == tag_q[idx]);
      if (held[idx] && !clash && cnt < (PW+1)'(NUM_WPORTS)) begin
        grant[idx] = 1'b1;
        port_v[cnt[PW-1:0]] = 1'b1;
        port_tag[cnt[PW-1:0]] = tag_q[idx];
        port_data[cnt[PW-1:0]] = data_q[idx];
        cnt = cnt + 1'b1;
        last = idx;
      end
    end
    rr_nxt = |grant ? (last == RW'(NUM_REQ-1) ? '0 : last + 1'b1) : rr_ptr;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      held <= '0;
      rr_ptr <= '0;
      WriteEnable_OUT <= '0;
      sel_q <= '0;
      wdat_q <= '0;
    end else begin
      held <= (held & ~grant) | xfer;
      rr_ptr <= rr_nxt;
      WriteEnable_OUT <= port_v;
      sel_q <= port_tag;
      wdat_q <= port_data;
    end
  always_ff @(posedge CLK)
    for (int i = 0; i < NUM_REQ; i++)
      if (xfer[i]) begin
        tag_q[i] <= in_tag[i];
        data_q[i] <= in_data[i];
      end
`ifdef PRF_WB_STATS_EN
  logic [31:0] stall_cnt;
  assign Stall_Count_OUT = stall_cnt;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET)
      stall_cnt <= '0;
    else if (|(held & ~grant) && !(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_phys_reg_wb_arbiter.sv
// tb_phys_reg_wb_arbiter: directed scenarios plus random traffic checked against a per-cycle reference model.
module tb_phys_reg_wb_arbiter;
  localparam int NR = 6, NW = 4, RL = 6;
  logic CLK = 1'b0, RESET = 1'b0;
  logic [NR-1:0] valid = '0;
  logic [NR-1:0][RL-1:0] tag = '0;
  logic [NR-1:0][31:0] data = '0;
  logic [NR-1:0] ready;
  logic [NW-1:0] we;
  logic [NW-1:0][RL-1:0] sel;
  logic [NW-1:0][31:0] wdat;
`ifdef PRF_WB_STATS_EN
  logic [31:0] stall;
`endif
  int checks = 0, errors = 0;
  int m_ptr, m_n;
  int m_tag[NR];
  logic [31:0] m_data[NR];
  logic [NR-1:0] m_held, m_gr;
  int m_port[NW];
  logic [NW-1:0] e_we;
  int e_sel[NW];
  logic [31:0] e_dat[NW];
  logic [31:0] m_stall;
  always #5 CLK = ~CLK;
  phys_reg_wb_arbiter dut (
    .CLK(CLK),
    .RESET(RESET),
    .Req_Valid_IN(valid),
    .Req_Tag_IN(tag),
    .Req_Data_IN(data),
    .Req_Ready_OUT(ready),
    .WriteEnable_OUT(we),
    .RegSelect_OUT(sel),
    .WData_OUT(wdat)
`ifdef PRF_WB_STATS_EN
    ,
    .Stall_Count_OUT(stall)
`endif
  );
  task automatic chk(string t, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", t, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    m_held = '0;
    m_ptr = 0;
    e_we = '0;
    m_stall = '0;
  endtask
  // Up to NW held entries in round-robin order from m_ptr, no two with the same tag.
  task automatic model_scan();
    m_gr = '0;
    m_n = 0;
    for (int s = 0; s < NR; s++) begin
      int i;
      bit dup;
      i = (m_ptr + s) % NR;
      dup = 0;
      for (int k = 0; k < m_n; k++)
        if (m_tag[m_port[k]] == m_tag[i]) dup = 1;
      if (m_held[i] && !dup && m_n < NW) begin
        m_gr[i] = 1'b1;
        m_port[m_n] = i;
        m_n++;
      end
    end
  endtask
  task automatic step();
    logic [NR-1:0] exp_rdy, acc;
    #1;
    model_scan();
    exp_rdy = ~m_held | m_gr;
    chk("ready", ready, exp_rdy);
    acc = valid & exp_rdy;
    @(posedge CLK);
    if ((m_held & ~m_gr) != 0 && m_stall != 32'hFFFFFFFF) m_stall++;
    e_we = '0;
    for (int k = 0; k < m_n; k++) begin
      e_we[k] = 1'b1;
      e_sel[k] = m_tag[m_port[k]];
      e_dat[k] = m_data[m_port[k]];
    end
    if (m_n > 0) m_ptr = (m_port[m_n-1] + 1) % NR;
    for (int i = 0; i < NR; i++) begin
      if (m_gr[i]) m_held[i] = 1'b0;
      if (acc[i]) begin
        m_held[i] = 1'b1;
        m_tag[i] = int'(tag[i]);
        m_data[i] = data[i];
      end
    end
    @(negedge CLK);
    chk("we", we, e_we);
    for (int k = 0; k < NW; k++)
      if (e_we[k]) begin
        chk("sel", sel[k], e_sel[k]);
        chk("wdata", wdat[k], e_dat[k]);
      end
    chk("rr_ptr", dut.rr_ptr, m_ptr);
    chk("held", dut.held, m_held);
`ifdef PRF_WB_STATS_EN
    chk("stall", stall, m_stall);
`endif
  endtask
  task automatic do_reset();
    #2 RESET = 1'b0;
    #1;
    chk("rst_ready", ready, 6'h3F);
    chk("rst_we", we, 0);
    chk("rst_ptr", dut.rr_ptr, 0);
    chk("rst_held", dut.held, 0);
    @(negedge CLK);
    valid = '0;
    chk("rst_we2", we, 0);
    chk("rst_ready2", ready, 6'h3F);
`ifdef PRF_WB_STATS_EN
    chk("rst_stall", stall, 0);
`endif
    RESET = 1'b1;
    model_clear();
  endtask
  task automatic rand_in(int pct);
    for (int i = 0; i < NR; i++) begin
      valid[i] = $urandom_range(99) < pct;
      tag[i] = RL'($urandom_range(7));
      data[i] = $urandom;
    end
  endtask
  initial begin
    repeat (2) @(negedge CLK);
    chk("init_ready", ready, 6'h3F);
    chk("init_we", we, 0);
    chk("init_sel", sel, 0);
    chk("init_wdat0", wdat[0], 0);
    chk("init_ptr", dut.rr_ptr, 0);
    RESET = 1'b1;
    model_clear();
    valid = 6'b000100;
    tag[2] = 6'd5;
    data[2] = 32'hDEADBEEF;
    step();
    valid = '0;
    chk("s1_lat", we, 0);
    step();
    chk("s1_we", we, 4'b0001);
    chk("s1_sel", sel[0], 5);
    chk("s1_data", wdat[0], 32'hDEADBEEF);
    chk("s1_ptr", dut.rr_ptr, 3);
    do_reset();
    valid = '1;
    for (int i = 0; i < NR; i++) begin
      tag[i] = RL'(10 + i);
      data[i] = 32'(100 + i);
    end
    step();
    valid = '0;
    #1 chk("s2_rdy", ready, 6'b001111);
    step();
    chk("s2_we1", we, 4'b1111);
    for (int k = 0; k < NW; k++) chk("s2_sel1", sel[k], 10 + k);
    step();
    chk("s2_we2", we, 4'b0011);
    chk("s2_sel2a", sel[0], 14);
    chk("s2_sel2b", sel[1], 15);
    do_reset();
    valid = 6'b001010;
    tag[1] = 6'd7;
    tag[3] = 6'd7;
    data[1] = 32'd1;
    data[3] = 32'd2;
    step();
    valid = '0;
    step();
    chk("s3_we1", we, 4'b0001);
    chk("s3_data1", wdat[0], 1);
    step();
    chk("s3_we2", we, 4'b0001);
    chk("s3_sel2", sel[0], 7);
    chk("s3_data2", wdat[0], 2);
    do_reset();
    for (int n = 0; n < 10; n++) begin
      valid = 6'b000001;
      tag[0] = RL'(n);
      data[0] = 32'(n);
      #1 chk("s4_rdy", ready[0], 1);
      step();
      if (n > 0) begin
        chk("s4_we", we, 4'b0001);
        chk("s4_data", wdat[0], n - 1);
      end
    end
    valid = '0;
    step();
    chk("s4_last", wdat[0], 9);
    do_reset();
    valid = 6'b000111;
    for (int i = 0; i < 3; i++) tag[i] = RL'(30 + i);
    step();
    valid = '0;
    chk("s5_held", dut.held, 6'b000111);
    do_reset();
    step();
    step();
    chk("s5_we", we, 0);
    chk("s5_ptr", dut.rr_ptr, 0);
`ifdef PRF_WB_STATS_EN
    do_reset();
    valid = '1;
    for (int i = 0; i < NR; i++) tag[i] = RL'(20 + i);
    step();
    valid = '0;
    step();
    chk("s6_stall1", stall, 1);
    step();
    chk("s6_stall2", stall, 1);
    force dut.stall_cnt = 32'hFFFFFFFF;
    #1 release dut.stall_cnt;
    m_stall = 32'hFFFFFFFF;
    valid = '1;
    step();
    valid = '0;
    step();
    chk("s6_sat", stall, 32'hFFFFFFFF);
    step();
`endif
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(199) == 0) do_reset();
      rand_in(60);
      step();
    end
    valid = '0;
    repeat (8) step();
    chk("drain_held", dut.held, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/phys_reg_wb_arbiter.md
PHYS_REG_WB_ARBITER -- requirements
Module: phys_reg_wb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_PHYS_REGS, 64, physical register count; REGLINES = clog2(NUM_PHYS_REGS).
- NUM_REQ, 6, writeback requesters (functional units).
- NUM_WPORTS, 4, register-file write ports driven.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK, input, 1, sole clock, rising edge.
- RESET, input, 1, asynchronous, active-low reset.
- Req_Valid_IN, input, NUM_REQ, requester i offers a result.
- Req_Tag_IN, input, NUM_REQ*REGLINES, destination physical register per requester; slice i.
- Req_Data_IN, input, NUM_REQ*32, result data per requester; slice i.
- Req_Ready_OUT, output, NUM_REQ, requester i may hand over this cycle.
- WriteEnable_OUT, output, NUM_WPORTS, per-port write strobe to the register file.
- RegSelect_OUT, output, NUM_WPORTS*REGLINES, per-port register index.
- WData_OUT, output, NUM_WPORTS*32, per-port write data.
- Stall_Count_OUT, output, 32, stall statistic; present only with PRF_WB_STATS_EN.

Function
REQ-003 Each requester SHALL own one holding entry {Held, Tag, Data}.
REQ-004 Req_Ready_OUT[i] SHALL be combinational: 1 when Held[i]=0 or entry i is granted this cycle.
REQ-005 A transfer SHALL occur at a rising edge with Req_Valid_IN[i]&Req_Ready_OUT[i]; the entry then loads Tag/Data and Held[i]=1.
REQ-006 Each cycle, the block SHALL grant up to NUM_WPORTS held entries, scanning round-robin from RR_Ptr upward, wrapping NUM_REQ-1 to 0.
REQ-007 The k-th granted entry in scan order SHALL map to write port k; unused ports have WriteEnable_OUT=0.
REQ-008 At the edge ending a grant cycle, the port registers SHALL latch the granted tag/data, WriteEnable_OUT SHALL be 1 for exactly one cycle, and Held SHALL clear unless a new transfer reloads the entry the same edge.
REQ-009 Latency: a transfer at edge k SHALL produce WriteEnable_OUT high in the cycle after edge k+1 at the earliest.
REQ-010 RR_Ptr SHALL advance to (last granted index + 1) mod NUM_REQ, and SHALL remain unchanged when nothing is granted.
REQ-011 Two held entries with equal Tag SHALL NOT be granted in the same cycle; the later one in scan order is skipped and stays held.
REQ-012 Full case: with more held entries than NUM_WPORTS, the excess SHALL stay held, and Req_Ready_OUT for those requesters SHALL be 0.
REQ-013 Held entries SHALL never be dropped or reordered per requester; results from one requester SHALL be written in acceptance order.
REQ-014 When no entry is held, all WriteEnable_OUT bits SHALL be 0 at the next edge.

Reset
REQ-015 RESET low SHALL asynchronously clear Held, RR_Ptr=0, WriteEnable_OUT=0, RegSelect_OUT=0, WData_OUT=0 and Stall_Count_OUT=0.
REQ-016 Reset mid-operation SHALL discard all held entries without any write strobe, and Req_Ready_OUT SHALL read all-ones while reset is low.
REQ-017 The first transfer SHALL be accepted at the first rising edge after RESET deasserts.

Configuration
REQ-018 With PRF_WB_STATS_EN defined, Stall_Count_OUT SHALL increment by 1 each cycle in which at least one held entry is not granted, saturating at 0xFFFFFFFF.
REQ-019 Without PRF_WB_STATS_EN, the Stall_Count_OUT port and counter SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Reset, then one request (req2, tag 5, data 0xDEADBEEF): WriteEnable_OUT=0001, port0 tag 5, data 0xDEADBEEF, two cycles after the transfer, and RR_Ptr=3.
- All 6 requesters valid with tags 10..15 from RR_Ptr=0: cycle 1 writes tags 10..13 on ports 0..3; cycle 2 writes 14, 15 on ports 0..1; req4/req5 Ready=0 during cycle 1.
- Req1 and req3 both hold tag 7 (data 1 and 2): data 1 written first, data 2 written the next cycle, never on the same cycle.
- Req0 streams back-to-back every cycle with others idle: Ready stays 1 and one write per cycle in order.
- RESET pulsed low while 3 entries are held: no WriteEnable_OUT afterwards, Held cleared, and RR_Ptr=0.
- With PRF_WB_STATS_EN, 6 requests held for 2 cycles with NUM_WPORTS=4: Stall_Count_OUT=1 after the first grant cycle, and the counter holds at 0xFFFFFFFF once forced there.
